// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Package     : debounce_pkg
// Description : Shared constants for the din_debounce block: filter FSM state
//               encoding and the default synchronizer depth / qualify length.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_LOW  = 2'b00;
    localparam logic [ST_W-1:0] ST_RISE = 2'b01;
    localparam logic [ST_W-1:0] ST_HIGH = 2'b10;
    localparam logic [ST_W-1:0] ST_FALL = 2'b11;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : STAGES-deep flop chain that brings an asynchronous level into
//               the clk domain. All stages clear to 0 on reset.
// Ports       : clk  - rising-edge clock
//               res  - synchronous active-high reset
//               d    - asynchronous input
//               q    - synchronized output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (res) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/din_debounce.sv
`default_nettype none
// ============================================================================
// Module      : din_debounce
// Description : Debounces a raw asynchronous input into a clean level with
//               one-cycle rise/fall pulses. Synchronizer -> stability counter
//               -> 4-state filter FSM (LOW / RISE / HIGH / FALL).
// Ports       : clk  - rising-edge clock
//               res  - synchronous active-high reset
//               din  - raw asynchronous input
//               tick - sample-enable strobe for the stability counter
//               q    - debounced level (registered)
//               rise - one-cycle pulse as q goes 0->1
//               fall - one-cycle pulse as q goes 1->0
//               busy - a candidate transition is being qualified
// Revision    : 1.0 - initial release
// ============================================================================
module din_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic res,
    input  logic din,
    input  logic tick,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             w_s;
    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q;
    logic             w_q_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .res (res),
        .d   (din),
        .q   (w_s)
    );

    // ------------------------------------------------------------------
    // State register (also holds counter, level and pulse registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // The first differing sample always opens a candidate (cnt=1) whatever
    // tick is; only the follow-up samples are gated by tick. A sample that
    // reverts the input cancels the candidate on any cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_LOW: begin
                w_q_nxt   = 1'b0;
                w_cnt_nxt = '0;
                if (w_s) begin
                    w_state_nxt = ST_RISE;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            ST_RISE: begin
                if (!w_s) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (tick && (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else if (tick) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_HIGH: begin
                w_q_nxt   = 1'b1;
                w_cnt_nxt = '0;
                if (!w_s) begin
                    w_state_nxt = ST_FALL;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            ST_FALL: begin
                if (w_s) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (tick && (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else if (tick) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
                w_q_nxt     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == ST_RISE) || (r_state == ST_FALL);
        q    = r_q;
        rise = r_rise;
        fall = r_fall;
    end

endmodule : din_debounce
`default_nettype wire

// File: tb/tb_din_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_din_debounce
// Description : Self-checking bench for din_debounce. A run-length model of
//               the debounce rule predicts q/rise/fall/busy every cycle;
//               directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_din_debounce;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clk;
    logic res;
    logic din;
    logic tick;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int n_tests;
    int n_fail;

    din_debounce #(
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC),
        .CNT_W         (16)
    ) dut (
        .clk  (clk),
        .res  (res),
        .din  (din),
        .tick (tick),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the input seen by the filter is din delayed SS
    // edges. A change is accepted once the first differing sample is
    // followed by SC-1 further differing samples taken on tick cycles,
    // with no reverting sample in between.
    // ------------------------------------------------------------------
    bit m_dly [SS];
    bit m_q;
    bit m_rise;
    bit m_fall;
    int m_run;    // 0: idle, >0: candidate open
    int m_ticks;  // ticked differing samples after the opening one

    task automatic model_edge(input bit d, input bit t, input bit r);
        bit s;
        s = m_dly[SS-1];
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            for (int i = 0; i < SS; i++) m_dly[i] = 1'b0;
            m_q = 1'b0;
            m_run = 0;
            m_ticks = 0;
            return;
        end
        for (int i = SS-1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = d;
        if (s == m_q) begin
            m_run = 0;
            m_ticks = 0;
        end else if (m_run == 0) begin
            m_run = 1;
            m_ticks = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == SC - 1) begin
                m_q = s;
                m_rise = s;
                m_fall = !s;
                m_run = 0;
                m_ticks = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, advance model at the rising
    // edge, compare the registered outputs 1 time unit later.
    task automatic step(input bit d, input bit t, input bit r);
        @(negedge clk);
        din  = d;
        tick = t;
        res  = r;
        @(posedge clk);
        model_edge(d, t, r);
        #1;
        chk("q",    q,    m_q);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("busy", busy, (m_run > 0));
        if (rise && fall) chk("rise_fall_exclusive", 1'b1, 1'b0);
    endtask

    int  fall_seen;
    bit  lvl;
    bit  dv;
    bit  tv;
    bit  rv;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        din  = 1'b0;
        tick = 1'b1;
        res  = 1'b1;
        for (int i = 0; i < SS; i++) m_dly[i] = 1'b0;
        m_q = 0; m_rise = 0; m_fall = 0; m_run = 0; m_ticks = 0;

        // ---- Reset held 3 cycles with din=1 ----
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1);
            chk("rst_q", q, 1'b0);
            chk("rst_rise", rise, 1'b0);
            chk("rst_fall", fall, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end
        for (int k = 1; k <= 7; k++) begin
            step(1, 1, 0);
            chk("rst_rel_rise", rise, (k == 6));
            chk("rst_rel_q", q, (k >= 6));
        end

        // ---- Clean step from idle ----
        step(0, 1, 1);
        for (int k = 0; k < 5; k++) step(0, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 0);
            chk("step_busy", busy, (k >= 3 && k <= 5));
            chk("step_rise", rise, (k == 6));
            chk("step_q", q, (k >= 6));
        end

        // ---- Falling edge with reset mid-qualify ----
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        chk("midrst_busy_before", busy, 1'b1);
        chk("midrst_q_before", q, 1'b1);
        step(0, 1, 1);
        chk("midrst_q", q, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_fall", fall, 1'b0);
        fall_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0);
            if (fall || busy || q) fall_seen++;
        end
        chk("midrst_quiet", (fall_seen != 0), 1'b0);

        // ---- Bounce rejection ----
        begin
            bit pat [5];
            pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0;
            fall_seen = 0;
            for (int k = 0; k < 5; k++) begin
                step(pat[k], 1, 0);
                if (rise || q) fall_seen++;
            end
            for (int k = 0; k < 8; k++) begin
                step(0, 1, 0);
                if (rise || q) fall_seen++;
            end
            chk("bounce_no_rise", (fall_seen != 0), 1'b0);
            chk("bounce_busy_idle", busy, 1'b0);
        end

        // ---- Prescaled tick: tick on every 3rd edge ----
        for (int k = 1; k <= 14; k++) begin
            step(1, (k % 3 == 0), 0);
            chk("presc_rise", rise, (k == 12));
            chk("presc_q", q, (k >= 12));
            if (rise) chk("presc_rise_on_tick", 1'b1, (k % 3 == 0));
        end

        // ---- Randomized run with glitches, sparse tick and rare reset ----
        lvl = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) lvl = ~lvl;
            dv = lvl;
            if ($urandom_range(0, 15) == 0) dv = ~lvl;
            tv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 399) == 0);
            step(dv, tv, rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound in case the clock or a wait ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule : tb_din_debounce
`default_nettype wire

// File: doc/din_debounce.md
Name: din_debounce

Overview:
- Conditions a raw, asynchronous, possibly bouncing input (push-button or switch) into a clean, single-clock-domain level.
- Also produces one-cycle edge pulses.
- Sits directly upstream of the team's synchronous-reset D flip-flop stages and drives their d input.
- Consists of an N-stage synchronizer, a stability counter and a 4-state filter FSM.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on din (legal range 2..4).
- STABLE_CYCLES, 4, consecutive qualifying samples required before the output level changes (legal range 2..2^CNT_W-1).
- CNT_W, 16, stability counter width.

Ports:
- clk  input  1  rising-edge clock
- res  input  1  reset; synchronous, active-high
- din  input  1  raw asynchronous input
- tick  input  1  sample-enable strobe for the counter; tie to 1 for per-clock sampling
- q  output  1  debounced level, registered
- rise  output  1  one-cycle pulse, coincident with q going 0->1
- fall  output  1  one-cycle pulse, coincident with q going 1->0
- busy  output  1  high while a candidate transition is being qualified (state RISE or FALL)

Behaviour:
- Reset: res=1 at a clk edge clears all synchronizer flops, cnt, q, rise and fall to 0, and sets state to LOW. Reset has priority over every other condition. A transition in progress is abandoned with no pulse.
- Synchronizer: s is the last stage of the SYNC_STAGES chain. The FSM and counter look only at s, never at din.
- States:
  - LOW: q=0. If s=1, go to RISE with cnt<=1.
  - RISE:
    - If s=0, go to LOW with cnt<=0 (glitch rejected, no pulse). The s check applies every cycle, whatever tick is.
    - Else if tick=1 and cnt==STABLE_CYCLES-1: go to HIGH, q<=1, rise<=1.
    - Else if tick=1: cnt<=cnt+1.
    - Else: hold.
  - HIGH: q=1. If s=0, go to FALL with cnt<=1.
  - FALL: mirror of RISE with s inverted. Exit to HIGH on a glitch, or to LOW with q<=0 and fall<=1.
- Latency with tick=1 and a clean step: q changes exactly SYNC_STAGES+STABLE_CYCLES clock edges after the first edge that samples the new din. With defaults this is 6.
- rise and fall are high for exactly one cycle. They are never high together. Neither is high in a reset cycle.
- busy = (state==RISE) or (state==FALL), decoded from registered state.
- Counter: cnt never exceeds STABLE_CYCLES-1 and never wraps. It is cleared on every return to LOW or HIGH.
- A bounce shorter than STABLE_CYCLES qualifying samples never changes q.
- Entering RISE on the cycle an edge qualifies: not possible. HIGH is entered first and is evaluated on the next cycle.
- Illegal state encodings recover to LOW with q=0 on the next edge.

Decomposition:
- Shared package debounce_pkg holds:
  - state encoding constants ST_LOW=2'b00, ST_RISE=2'b01, ST_HIGH=2'b10, ST_FALL=2'b11;
  - the default values of SYNC_STAGES and STABLE_CYCLES.
- One sub-module, sync_chain. It is a parameterized SYNC_STAGES-deep flop chain with the same clk/res convention and a reset value of 0.
- The FSM, counter and pulse generation live in din_debounce.

Test Plan:
- Reset: hold res=1 for 3 cycles with din=1, then release. Required: q=rise=fall=busy=0 during reset. Rise asserts on the 6th edge after release.
- Clean step: defaults, tick=1, din 0->1 and held. Required: q=1 and rise=1 on edge 6 after the step. rise=0 on edge 7. busy=1 on edges 3-5.
- Bounce rejection: din pattern 1,0,1,1,0 at one cycle each, then 0. Required: q stays 0, rise never asserts, busy returns to 0.
- Prescaled tick: tick=1 every 3rd cycle, din 0->1 held. Required: q rises only after 3 counted ticks following entry to RISE. No rise pulse while tick=0.
- Falling edge with mid-qualify reset: start from q=1, drop din to 0, and assert res for 1 cycle while busy=1. Required: q=0, fall never pulses, state LOW. With din still 0, there is no further activity.
